// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the single-issue ALU sequencer.
//   alu_op_t : 4-bit ALU operation codes presented on alu_op
//   OP/OP_IMM: RV32I major opcodes handled by the block
//   b_sel_t  : source of the second ALU operand
//   state_t  : sequencer states (IDLE -> EXEC -> WB -> IDLE)
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // funct7 values: base encoding and the SUB/SRA alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    B_RS2   = 2'd0,
    B_IMM   = 2'd1,
    B_SHAMT = 2'd2
  } b_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode -- combinational RV32I OP / OP-IMM decoder.
//   opcode  (in)  instruction bits [6:0]
//   funct3  (in)  instruction bits [14:12]
//   funct7  (in)  instruction bits [31:25]
//   alu_op  (out) ALU operation code
//   b_sel   (out) second operand source: rs2, sign-extended imm or shamt
//   illegal (out) encoding not supported by this block
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_op,
  output b_sel_t     b_sel,
  output logic       illegal
);

  alu_op_t base_op;

  // funct3 selects the operation family; funct7 only refines 000 and 101
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op  = base_op;
    b_sel   = B_RS2;
    illegal = 1'b0;

    if (opcode == OP) begin
      b_sel = B_RS2;
      if (funct7 == F7_ALT) begin
        if (funct3 == 3'b000)      alu_op  = ALU_SUB;
        else if (funct3 == 3'b101) alu_op  = ALU_SRA;
        else                       illegal = 1'b1;
      end else if (funct7 != F7_BASE) begin
        illegal = 1'b1;
      end
    end else if (opcode == OP_IMM) begin
      b_sel = B_IMM;
      // Only the shift-immediates reuse imm[11:5] as funct7; no SUB form exists
      if (funct3 == 3'b001) begin
        b_sel = B_SHAMT;
        if (funct7 != F7_BASE) illegal = 1'b1;
      end else if (funct3 == 3'b101) begin
        b_sel = B_SHAMT;
        if (funct7 == F7_ALT)       alu_op  = ALU_SRA;
        else if (funct7 != F7_BASE) illegal = 1'b1;
      end
    end else begin
      illegal = 1'b1;
    end

    if (illegal) begin
      alu_op = ALU_ADD;
      b_sel  = B_RS2;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- single-instruction issue sequencer for RV32I ALU ops.
// Accepts one instruction in IDLE, drives an external ALU for one EXEC
// cycle, then holds a writeback record in WB until it is consumed.
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     instruction handshake, in_instr = instruction word
//   rs1_addr/rs2_addr     register-file read addresses (combinational)
//   rs1_data/rs2_data     register-file read data, same cycle
//   alu_a/alu_b/alu_op    operands and op to the external ALU (zero outside EXEC)
//   alu_result/alu_zero   combinational ALU response
//   wb_valid/wb_ready     writeback handshake
//   wb_rd/wb_data/wb_zero/wb_we/wb_illegal   writeback record
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_zero,
  output logic            wb_we,
  output logic            wb_illegal
);

  state_t          state_q, state_d;
  alu_op_t         op_q;
  logic [XLEN-1:0] a_q, b_q;

  alu_op_t         dec_op;
  b_sel_t          dec_b_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] b_operand;
  logic            accept;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_decode u_decode (
    .opcode  (in_instr[6:0]),
    .funct3  (in_instr[14:12]),
    .funct7  (in_instr[31:25]),
    .alu_op  (dec_op),
    .b_sel   (dec_b_sel),
    .illegal (dec_illegal)
  );

  always_comb begin
    b_operand = rs2_data;
    case (dec_b_sel)
      B_RS2:   b_operand = rs2_data;
      B_IMM:   b_operand = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      B_SHAMT: b_operand = {{(XLEN-5){1'b0}}, in_instr[24:20]};
      default: b_operand = rs2_data;
    endcase
  end

  // in_ready is gated by rst_n so nothing is offered acceptance during reset
  assign in_ready = rst_n && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign wb_valid = (state_q == ST_WB);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   if (wb_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (state_q == ST_EXEC) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
  end

  // The writeback control fields (rd, we, illegal) are latched straight into
  // the output registers at acceptance; wb_valid stays low until WB so the
  // early update is not observable as a record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      wb_illegal <= 1'b0;
      wb_data    <= '0;
      wb_zero    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wb_rd      <= in_instr[11:7];
        op_q       <= dec_op;
        a_q        <= dec_illegal ? '0 : rs1_data;
        b_q        <= dec_illegal ? '0 : b_operand;
        wb_illegal <= dec_illegal;
        wb_we      <= !dec_illegal && (in_instr[11:7] != 5'd0);
      end
      if (state_q == ST_EXEC) begin
        wb_data <= wb_illegal ? '0 : alu_result;
        wb_zero <= wb_illegal ? 1'b0 : alu_zero;
      end
    end
  end

endmodule
